bcd_mmss_timer: RTL and testbench
=================================

Name: bcd_mmss_timer

Overview:
Parametrised successor to the two-stage MM:SS chess clock counter. Holds one player's time as four BCD digits and supports up-count or count-down at run time, parallel BCD preload, and a Fischer-style bonus add. Also provides a sticky expiry flag. Sits between the 1 Hz impulse generator and the display mux; one instance per player.

Parameters:
MAX_MIN, 99, highest minute value (1..99); full-scale time is MAX_MIN:59.
BONUS_SEC, 5, seconds added on ADD_BONUS (0..59).

Ports:
CLK  input  1  system clock, rising edge.
CLR  input  1  asynchronous, active-high reset.
CE  input  1  count enable; gates IMPULSE only.
IMPULSE  input  1  one-cycle 1 Hz tick.
MODE  input  1  0 = count up, 1 = count down.
LOAD  input  1  one-cycle preload strobe.
LD_MIN_TENS  input  4  preload BCD digit.
LD_MIN_UNITS  input  4  preload BCD digit.
LD_SEC_TENS  input  4  preload BCD digit.
LD_SEC_UNITS  input  4  preload BCD digit.
ADD_BONUS  input  1  one-cycle strobe; add BONUS_SEC (count-down mode only).
min_tens, min_units, sec_tens, sec_units  output  4 each  current time, BCD, registered.
OVERFLOW  output  1  one-cycle pulse on up-count wrap.
EXPIRED  output  1  sticky; time reached 00:00 in count-down mode.
BONUS_LOST  output  1  one-cycle pulse when a tick was dropped.

Behaviour:
- CLR high (async): all digits 0, OVERFLOW 0, EXPIRED 0, BONUS_LOST 0. Takes effect immediately and holds while high.
- All updates happen on the CLK rising edge. Outputs reflect an event one cycle after the strobe is sampled.
- Event priority per cycle: LOAD > ADD_BONUS > tick. A tick is IMPULSE & CE.
- LOAD:
  - Each digit is clamped independently: units digits to 9, sec tens to 5.
  - Minutes are clamped to MAX_MIN, and seconds are then forced to 59 if the loaded minutes exceeded MAX_MIN.
  - LOAD clears EXPIRED.
  - If a tick coincides with LOAD, the tick is dropped and BONUS_LOST pulses.
- ADD_BONUS:
  - Acts only when MODE = 1 and EXPIRED = 0; otherwise it is ignored and any tick in that cycle proceeds normally.
  - Time becomes current + BONUS_SEC, using BCD seconds carry into minutes.
  - Result saturates at MAX_MIN:59.
  - A coincident tick is dropped and BONUS_LOST pulses.
- Tick, MODE = 0 (up):
  - sec units 9 -> 0 carries into sec tens; sec tens 5 -> 0 carries into minutes.
  - At MAX_MIN:59 a tick gives 00:00, and OVERFLOW = 1 for that one cycle.
  - EXPIRED is unaffected.
- Tick, MODE = 1 (down):
  - Decrement with BCD borrow: sec units 0 -> 9 borrows; sec tens 0 -> 5 borrows from minutes.
  - When the result is 00:00, EXPIRED sets in the same edge.
  - At 00:00 further ticks hold 00:00. No wrap, no OVERFLOW.
- EXPIRED clears only on CLR or LOAD.
- MODE change takes effect on the next tick. The current value is not altered.
- CE low: ticks are ignored. LOAD and ADD_BONUS still act.
- OVERFLOW and BONUS_LOST are 0 in every cycle without their triggering event.
- Invariants:
  - Digits are always valid BCD.
  - sec_tens <= 5.
  - Time <= MAX_MIN:59.

Test Plan:
- Reset: assert CLR mid-count at 12:34 -> outputs 00:00 and flags 0 immediately, without waiting for a clock edge. Release -> counting resumes from 00:00.
- Down-count to expiry: LOAD 00:02, MODE = 1, 3 ticks -> 00:01, then 00:00 with EXPIRED = 1, then still 00:00 with EXPIRED = 1.
- Up wrap: LOAD 99:58, MODE = 0, 2 ticks -> 99:59, then 00:00 with a single-cycle OVERFLOW pulse.
- Bonus: BONUS_SEC = 5.
  - 05:57 + ADD_BONUS -> 06:02.
  - 99:57 + ADD_BONUS -> 99:59 (saturated).
  - ADD_BONUS while EXPIRED -> no change.
- Collisions:
  - LOAD 03:00 with a tick in the same cycle -> 03:00 and BONUS_LOST pulse.
  - CE = 0 with 5 ticks -> value unchanged.
- Clamping with MAX_MIN = 30: LOAD 4F:7C -> 30:59.

Source files
------------

// File: rtl/bcd_mmss_timer.sv
// MM:SS player timer: four BCD digits, up or down counting, preload, Fischer bonus, expiry flag.
module bcd_mmss_timer #(
  parameter int unsigned MAX_MIN   = 99,
  parameter int unsigned BONUS_SEC = 5
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  input  logic       IMPULSE,
  input  logic       MODE,
  input  logic       LOAD,
  input  logic [3:0] LD_MIN_TENS,
  input  logic [3:0] LD_MIN_UNITS,
  input  logic [3:0] LD_SEC_TENS,
  input  logic [3:0] LD_SEC_UNITS,
  input  logic       ADD_BONUS,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       OVERFLOW,
  output logic       EXPIRED,
  output logic       BONUS_LOST
);

  localparam int unsigned DW = 4;
  localparam int unsigned VW = 7;
  localparam logic [VW-1:0] MAX_M  = VW'(MAX_MIN);
  localparam logic [VW-1:0] BONUS  = VW'(BONUS_SEC);
  localparam logic [VW-1:0] LAST_S = VW'(59);

  // Two BCD digits to a binary value 0..99.
  function automatic logic [VW-1:0] bcd2bin(input logic [DW-1:0] t, input logic [DW-1:0] u);
    return VW'(t) * VW'(10) + VW'(u);
  endfunction

  // Limit a BCD digit to its legal maximum.
  function automatic logic [DW-1:0] clamp_digit(input logic [DW-1:0] d, input logic [DW-1:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  logic [VW-1:0] cur_m, cur_s, nxt_m, nxt_s, ld_m, sum_s;
  logic          tick, bonus_ok;
  logic          nxt_exp, nxt_ovf, nxt_lost;

  assign cur_m    = bcd2bin(min_tens, min_units);
  assign cur_s    = bcd2bin(sec_tens, sec_units);
  assign tick     = IMPULSE & CE;
  assign bonus_ok = ADD_BONUS & MODE & ~EXPIRED;

  // Next time and flags; priority LOAD > ADD_BONUS > tick.
  always_comb begin
    nxt_m    = cur_m;
    nxt_s    = cur_s;
    nxt_exp  = EXPIRED;
    nxt_ovf  = 1'b0;
    nxt_lost = 1'b0;
    sum_s    = cur_s + BONUS;
    ld_m     = bcd2bin(clamp_digit(LD_MIN_TENS, DW'(9)), clamp_digit(LD_MIN_UNITS, DW'(9)));
    if (LOAD) begin
      if (ld_m > MAX_M) begin
        nxt_m = MAX_M;
        nxt_s = LAST_S;
      end else begin
        nxt_m = ld_m;
        nxt_s = bcd2bin(clamp_digit(LD_SEC_TENS, DW'(5)), clamp_digit(LD_SEC_UNITS, DW'(9)));
      end
      nxt_exp  = 1'b0;
      nxt_lost = tick;
    end else if (bonus_ok) begin
      if (sum_s > LAST_S) begin
        nxt_s = sum_s - VW'(60);
        nxt_m = cur_m + VW'(1);
      end else begin
        nxt_s = sum_s;
      end
      if (nxt_m > MAX_M) begin
        nxt_m = MAX_M;
        nxt_s = LAST_S;
      end
      nxt_lost = tick;
    end else if (tick) begin
      if (!MODE) begin
        if (cur_s == LAST_S) begin
          nxt_s = '0;
          if (cur_m >= MAX_M) begin
            nxt_m   = '0;
            nxt_ovf = 1'b1;
          end else begin
            nxt_m = cur_m + VW'(1);
          end
        end else begin
          nxt_s = cur_s + VW'(1);
        end
      end else begin
        if (cur_s != '0) begin
          nxt_s = cur_s - VW'(1);
        end else if (cur_m != '0) begin
          nxt_s = LAST_S;
          nxt_m = cur_m - VW'(1);
        end
        if (nxt_m == '0 && nxt_s == '0) nxt_exp = 1'b1;
      end
    end
  end

  // Time digits and flags register.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      min_tens   <= '0;
      min_units  <= '0;
      sec_tens   <= '0;
      sec_units  <= '0;
      OVERFLOW   <= 1'b0;
      EXPIRED    <= 1'b0;
      BONUS_LOST <= 1'b0;
    end else begin
      min_tens   <= DW'(nxt_m / VW'(10));
      min_units  <= DW'(nxt_m % VW'(10));
      sec_tens   <= DW'(nxt_s / VW'(10));
      sec_units  <= DW'(nxt_s % VW'(10));
      OVERFLOW   <= nxt_ovf;
      EXPIRED    <= nxt_exp;
      BONUS_LOST <= nxt_lost;
    end
  end

endmodule

// File: tb/tb_bcd_mmss_timer.sv
// Self-checking bench for bcd_mmss_timer: directed scenarios plus randomized run against a seconds-count model.
module tb_bcd_mmss_timer;

  localparam int BONUS = 5;

  logic       CLK, CLR, CE, IMPULSE, MODE, LOAD, ADD_BONUS;
  logic [3:0] ld_mt, ld_mu, ld_st, ld_su;
  logic [3:0] mt, mu, st, su, mt30, mu30, st30, su30;
  logic       ovf, expd, lost, ovf30, expd30, lost30;

  int checks = 0;
  int errors = 0;

  bcd_mmss_timer #(.MAX_MIN(99), .BONUS_SEC(BONUS)) dut (
    .CLK(CLK), .CLR(CLR), .CE(CE), .IMPULSE(IMPULSE), .MODE(MODE), .LOAD(LOAD),
    .LD_MIN_TENS(ld_mt), .LD_MIN_UNITS(ld_mu), .LD_SEC_TENS(ld_st), .LD_SEC_UNITS(ld_su),
    .ADD_BONUS(ADD_BONUS), .min_tens(mt), .min_units(mu), .sec_tens(st), .sec_units(su),
    .OVERFLOW(ovf), .EXPIRED(expd), .BONUS_LOST(lost));

  bcd_mmss_timer #(.MAX_MIN(30), .BONUS_SEC(BONUS)) dut30 (
    .CLK(CLK), .CLR(CLR), .CE(CE), .IMPULSE(IMPULSE), .MODE(MODE), .LOAD(LOAD),
    .LD_MIN_TENS(ld_mt), .LD_MIN_UNITS(ld_mu), .LD_SEC_TENS(ld_st), .LD_SEC_UNITS(ld_su),
    .ADD_BONUS(ADD_BONUS), .min_tens(mt30), .min_units(mu30), .sec_tens(st30), .sec_units(su30),
    .OVERFLOW(ovf30), .EXPIRED(expd30), .BONUS_LOST(lost30));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int t;
    bit exp;
    bit ovf;
    bit lost;
  } mstate_t;

  function automatic logic [15:0] obs99();
    return {mt, mu, st, su};
  endfunction

  function automatic logic [15:0] obs30();
    return {mt30, mu30, st30, su30};
  endfunction

  // Total seconds to packed BCD MM:SS.
  function automatic logic [15:0] to_bcd(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Reference behaviour on a plain seconds count.
  function automatic mstate_t step(input mstate_t s, input int maxm, input bit ld,
                                   input int lmt, input int lmu, input int lst, input int lsu,
                                   input bit bon, input bit tk, input bit md);
    mstate_t n;
    int full, m;
    full = maxm * 60 + 59;
    n = s;
    n.ovf = 0;
    n.lost = 0;
    if (ld) begin
      m = (lmt > 9 ? 9 : lmt) * 10 + (lmu > 9 ? 9 : lmu);
      n.t = (m > maxm) ? full : m * 60 + (lst > 5 ? 5 : lst) * 10 + (lsu > 9 ? 9 : lsu);
      n.exp = 0;
      n.lost = tk;
    end else if (bon && md && !s.exp) begin
      n.t = (s.t + BONUS > full) ? full : s.t + BONUS;
      n.lost = tk;
    end else if (tk) begin
      if (!md) begin
        if (s.t == full) begin
          n.t = 0;
          n.ovf = 1;
        end else n.t = s.t + 1;
      end else begin
        n.t = (s.t > 0) ? s.t - 1 : 0;
        if (n.t == 0) n.exp = 1;
      end
    end
    return n;
  endfunction

  // One clock: inputs applied at the falling edge, outputs settle 1 ns after the rising edge.
  task automatic cyc(input bit ld, input bit bon, input bit imp, input bit ce_v, input bit md);
    @(negedge CLK);
    LOAD = ld; ADD_BONUS = bon; IMPULSE = imp; CE = ce_v; MODE = md;
    @(posedge CLK);
    #1;
    LOAD = 0; ADD_BONUS = 0; IMPULSE = 0;
  endtask

  task automatic set_ld(input logic [15:0] v);
    {ld_mt, ld_mu, ld_st, ld_su} = v;
  endtask

  task automatic test_reset();
    if (obs99() !== 16'h0000 || {ovf, expd, lost} !== 3'b000) begin
      errors++; $display("FAIL reset_init: got %h flags %b, want 0000 flags 000", obs99(), {ovf, expd, lost});
    end
    checks++;
    @(negedge CLK); CLR = 0;
    set_ld(16'h1233);
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    if (obs99() !== 16'h1234) begin
      errors++; $display("FAIL reset_precount: got %h want 1234", obs99());
    end
    checks++;
    #2 CLR = 1;
    #1;
    if (obs99() !== 16'h0000 || {ovf, expd, lost} !== 3'b000) begin
      errors++; $display("FAIL reset_async: got %h flags %b, want 0000 flags 000", obs99(), {ovf, expd, lost});
    end
    checks++;
    cyc(0, 0, 1, 1, 0);
    if (obs99() !== 16'h0000) begin
      errors++; $display("FAIL reset_hold: got %h want 0000", obs99());
    end
    checks++;
    @(negedge CLK); CLR = 0;
    cyc(0, 0, 1, 1, 0);
    if (obs99() !== 16'h0001) begin
      errors++; $display("FAIL reset_resume: got %h want 0001", obs99());
    end
    checks++;
  endtask

  task automatic test_expiry();
    logic [15:0] want [3] = '{16'h0001, 16'h0000, 16'h0000};
    bit          wexp [3] = '{1'b0, 1'b1, 1'b1};
    set_ld(16'h0002);
    cyc(1, 0, 0, 1, 1);
    if (obs99() !== 16'h0002 || expd !== 1'b0) begin
      errors++; $display("FAIL expiry_load: got %h exp %b, want 0002 exp 0", obs99(), expd);
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 1);
      if (obs99() !== want[i] || expd !== wexp[i] || ovf !== 1'b0) begin
        errors++; $display("FAIL expiry_tick%0d: got %h exp %b ovf %b, want %h exp %b ovf 0",
                           i, obs99(), expd, ovf, want[i], wexp[i]);
      end
      checks++;
    end
    cyc(0, 1, 0, 1, 1);
    if (obs99() !== 16'h0000 || expd !== 1'b1) begin
      errors++; $display("FAIL bonus_expired: got %h exp %b, want 0000 exp 1", obs99(), expd);
    end
    checks++;
    #2 CLR = 1;
    #1;
    if (expd !== 1'b0) begin
      errors++; $display("FAIL expiry_clr: got exp %b want 0", expd);
    end
    checks++;
    @(negedge CLK); CLR = 0;
  endtask

  task automatic test_up_wrap();
    set_ld(16'h9958);
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    if (obs99() !== 16'h9959 || ovf !== 1'b0) begin
      errors++; $display("FAIL wrap_first: got %h ovf %b, want 9959 ovf 0", obs99(), ovf);
    end
    checks++;
    cyc(0, 0, 1, 1, 0);
    if (obs99() !== 16'h0000 || ovf !== 1'b1 || expd !== 1'b0) begin
      errors++; $display("FAIL wrap_second: got %h ovf %b exp %b, want 0000 ovf 1 exp 0", obs99(), ovf, expd);
    end
    checks++;
    cyc(0, 0, 0, 1, 0);
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL wrap_pulse: got ovf %b want 0", ovf);
    end
    checks++;
  endtask

  task automatic test_bonus();
    set_ld(16'h0557);
    cyc(1, 0, 0, 1, 1);
    cyc(0, 1, 0, 1, 1);
    if (obs99() !== 16'h0602) begin
      errors++; $display("FAIL bonus_carry: got %h want 0602", obs99());
    end
    checks++;
    set_ld(16'h9957);
    cyc(1, 0, 0, 1, 1);
    cyc(0, 1, 1, 1, 1);
    if (obs99() !== 16'h9959 || lost !== 1'b1) begin
      errors++; $display("FAIL bonus_sat: got %h lost %b, want 9959 lost 1", obs99(), lost);
    end
    checks++;
    cyc(0, 1, 1, 1, 0);
    if (obs99() !== 16'h0000 || lost !== 1'b0 || ovf !== 1'b1) begin
      errors++; $display("FAIL bonus_upmode: got %h lost %b ovf %b, want 0000 lost 0 ovf 1", obs99(), lost, ovf);
    end
    checks++;
  endtask

  task automatic test_collision();
    set_ld(16'h0300);
    cyc(1, 0, 1, 1, 0);
    if (obs99() !== 16'h0300 || lost !== 1'b1) begin
      errors++; $display("FAIL load_tick: got %h lost %b, want 0300 lost 1", obs99(), lost);
    end
    checks++;
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0);
    if (obs99() !== 16'h0300 || lost !== 1'b0) begin
      errors++; $display("FAIL ce_low: got %h lost %b, want 0300 lost 0", obs99(), lost);
    end
    checks++;
  endtask

  task automatic test_clamp();
    set_ld(16'h4F7C);
    cyc(1, 0, 0, 1, 0);
    if (obs30() !== 16'h3059) begin
      errors++; $display("FAIL clamp_max30: got %h want 3059", obs30());
    end
    checks++;
    if (obs99() !== 16'h4959) begin
      errors++; $display("FAIL clamp_max99: got %h want 4959", obs99());
    end
    checks++;
  endtask

  task automatic test_random();
    mstate_t a, b;
    bit ld, bon, imp, ce_v, md;
    int lmt, lmu, lst, lsu;
    @(negedge CLK); CLR = 1;
    @(negedge CLK); CLR = 0;
    a = '{t: 0, exp: 0, ovf: 0, lost: 0};
    b = a;
    md = 0;
    for (int i = 0; i < 3000; i++) begin
      ld   = ($urandom_range(0, 19) == 0);
      bon  = ($urandom_range(0, 9) == 0);
      imp  = ($urandom_range(0, 1) == 1);
      ce_v = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) md = ~md;
      lmt = $urandom_range(0, 15); lmu = $urandom_range(0, 15);
      lst = $urandom_range(0, 15); lsu = $urandom_range(0, 15);
      set_ld({4'(lmt), 4'(lmu), 4'(lst), 4'(lsu)});
      a = step(a, 99, ld, lmt, lmu, lst, lsu, bon, imp & ce_v, md);
      b = step(b, 30, ld, lmt, lmu, lst, lsu, bon, imp & ce_v, md);
      cyc(ld, bon, imp, ce_v, md);
      if ({obs99(), ovf, expd, lost} !== {to_bcd(a.t), a.ovf, a.exp, a.lost}) begin
        errors++; $display("FAIL rand99 cyc %0d: got %h %b%b%b want %h %b%b%b", i,
                           obs99(), ovf, expd, lost, to_bcd(a.t), a.ovf, a.exp, a.lost);
      end
      checks++;
      if ({obs30(), ovf30, expd30, lost30} !== {to_bcd(b.t), b.ovf, b.exp, b.lost}) begin
        errors++; $display("FAIL rand30 cyc %0d: got %h %b%b%b want %h %b%b%b", i,
                           obs30(), ovf30, expd30, lost30, to_bcd(b.t), b.ovf, b.exp, b.lost);
      end
      checks++;
    end
  endtask

  initial begin
    CLR = 1; CE = 0; IMPULSE = 0; MODE = 0; LOAD = 0; ADD_BONUS = 0;
    set_ld(16'h0000);
    #12;
    test_reset();
    test_expiry();
    test_up_wrap();
    test_bonus();
    test_collision();
    test_clamp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
